vector_shader_core: RTL and testbench
=====================================

// Module: vector_shader_core
// PURPOSE
//   Next-generation SIMD shader core: VEC_SIZE lanes x DATA_WIDTH, private NUM_REGS vector register file,
//   built-in lane ALU, per-instruction lane mask, load/store over a req/ready memory port.
//   Sits between the main controller (valid/ready instruction issue) and data memory.
//   2-stage pipeline: EX (RF read + ALU) -> WB (RF write), with RAW hazard handling and memory stalls.
// PARAMETERS
//   DATA_WIDTH  32  bits per lane
//   VEC_SIZE    4   lanes per vector register
//   NUM_REGS    16  vector registers; RW = $clog2(NUM_REGS)
// PORTS
//   clk            in   1                    clock
//   rst            in   1                    synchronous active-high reset
//   i_instr_valid  in   1                    instruction present
//   o_instr_ready  out  1                    core accepts instruction this cycle
//   i_opcode       in   5                    0 ADD,1 SUB,2 MUL,3 AND,4 OR,5 XOR,6 LD,7 ST,else NOP
//   i_rd_addr      in   RW                   destination register
//   i_rs1_addr     in   RW                   source A (LD/ST: lane 0 = address)
//   i_rs2_addr     in   RW                   source B (ST: store data)
//   i_lane_mask    in   VEC_SIZE             lane write enables for rd
//   o_mem_req      out  1                    memory request pending
//   o_mem_we       out  1                    1 = store, 0 = load
//   o_mem_addr     out  DATA_WIDTH           lane 0 of rs1
//   o_mem_wdata    out  VEC_SIZE*DATA_WIDTH  rs2 vector
//   i_mem_ready    in   1                    memory completes request this cycle
//   i_mem_rdata    in   VEC_SIZE*DATA_WIDTH  load data, valid when i_mem_ready
//   o_busy         out  1                    WB valid or memory op outstanding
// BEHAVIOUR
//   - Accept = i_instr_valid & o_instr_ready at cycle T. Operands read from RF in T.
//   - ALU ops: lane-wise, modulo 2^DATA_WIDTH (ADD/SUB wrap; MUL keeps low DATA_WIDTH bits).
//     Result registered into WB at end of T; RF written at end of T+1; visible to RF read at T+2.
//   - Only masked lanes written; unmasked lanes of rd keep old value. Mask 0 or NOP: no write.
//   - No hardwired zero register; all registers reset to 0.
//   - FSM: IDLE (ready=1 unless hazard) / MEM (ready=0).
//     LD/ST accepted at T -> MEM; addr/wdata/we latched at T; o_mem_req=1 from T+1 until the
//     cycle i_mem_ready=1 (inclusive); then IDLE next cycle. i_mem_ready while req=0 ignored.
//     LD: i_mem_rdata captured into WB on handshake cycle, RF written next cycle. ST: no RF write.
//   - RAW hazard: accepted instr whose rs1 or rs2 equals WB.rd while WB valid with nonzero mask.
//   - Same-cycle WB write and RF read of same reg, no hazard path: read returns old value (hence hazard rule).
//   - Reset: o_instr_ready=0 during reset, 1 first cycle after; o_mem_req=0, o_mem_we=0,
//     o_mem_addr=0, o_mem_wdata=0, o_busy=0, WB invalid, RF cleared.
//     Reset mid-MEM abandons request (req low next cycle, no write).
// CONFIGURATION
//   SHADER_FWD_EN defined: WB result bypassed to EX operand on RAW hazard (per lane: masked lanes
//     take WB data, unmasked lanes take RF); no stall; back-to-back dependent ops at 1 per cycle.
//   SHADER_FWD_EN undefined: o_instr_ready=0 for one cycle on RAW hazard (combinational on
//     i_rs*_addr and WB state); instruction accepted next cycle.
// TESTING
//   - Reset, then R1=R2=0: ADD R3,R1,R2 mask 4'hF -> R3 all lanes 0; o_busy=1 for one cycle only.
//   - Preload R1 lanes {1,2,3,0xFFFFFFFF}, R2 all 1: ADD R4 mask 4'b0101 -> R4 {2,0,4,0}
//     (lane3 wrap masked off); SUB R5=R1-R2 mask F -> lane0 0, lane3 0xFFFFFFFE.
//   - ADD R6,R1,R2 then MUL R7,R6,R6 back-to-back: FWD_EN -> both accepted consecutive cycles,
//     R7 lane0 = 4; no FWD_EN -> ready low exactly 1 cycle, same R7 result.
//   - ST R1(addr lane0=0x100),R2 with i_mem_ready delayed 3 cycles -> o_mem_req high 3 cycles,
//     o_mem_we=1, addr 0x100, ready low throughout; LD R8 rdata lanes {A,B,C,D} mask F -> R8 = {A,B,C,D}.
//   - rst asserted while o_mem_req=1 for LD R9 -> req low next cycle, R9 stays 0, ready=1 after reset.
//   - Opcode 31 with valid -> accepted, no RF change, no memory request.

Source files
------------

// File: rtl/vector_shader_core.sv
// SIMD shader core: VEC_SIZE lanes, private vector register file, lane ALU, load/store port.
// Optional `SHADER_FWD_EN` bypasses the WB result into EX instead of stalling on RAW hazards.
module vector_shader_core #(
   parameter int DATA_WIDTH = 32,
   parameter int VEC_SIZE   = 4,
   parameter int NUM_REGS   = 16,
   localparam int RW        = $clog2(NUM_REGS),
   localparam int VW        = VEC_SIZE * DATA_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_instr_valid,
   output logic                o_instr_ready,
   input  logic [4:0]          i_opcode,
   input  logic [RW-1:0]       i_rd_addr,
   input  logic [RW-1:0]       i_rs1_addr,
   input  logic [RW-1:0]       i_rs2_addr,
   input  logic [VEC_SIZE-1:0] i_lane_mask,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_addr,
   output logic [VW-1:0]       o_mem_wdata,
   input  logic                i_mem_ready,
   input  logic [VW-1:0]       i_mem_rdata,
   output logic                o_busy
);

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_MUL = 5'd2;
   localparam logic [4:0] OP_AND = 5'd3;
   localparam logic [4:0] OP_OR  = 5'd4;
   localparam logic [4:0] OP_XOR = 5'd5;
   localparam logic [4:0] OP_LD  = 5'd6;
   localparam logic [4:0] OP_ST  = 5'd7;

   typedef enum logic {ST_IDLE = 1'b0, ST_MEM = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [VW-1:0]       rf_q [NUM_REGS];
   logic                wb_valid_q, wb_valid_d;
   logic [RW-1:0]       wb_rd_q, wb_rd_d;
   logic [VEC_SIZE-1:0] wb_mask_q, wb_mask_d;
   logic [VW-1:0]       wb_data_q, wb_data_d;
   logic                mem_we_q;
   logic [DATA_WIDTH-1:0] mem_addr_q;
   logic [VW-1:0]       mem_wdata_q;
   logic [RW-1:0]       ld_rd_q;
   logic [VEC_SIZE-1:0] ld_mask_q;

   logic [VW-1:0] rs1_rf, rs2_rf, op_a, op_b, alu_res, wb_merge;
   logic          hit_a, hit_b, instr_ready, accept;
   logic          is_alu, is_ld, is_st, mem_handshake;

   assign rs1_rf = rf_q[i_rs1_addr];
   assign rs2_rf = rf_q[i_rs2_addr];

   // A WB entry only matters for hazards if it will actually write some lane.
   assign hit_a = wb_valid_q & (|wb_mask_q) & (i_rs1_addr == wb_rd_q);
   assign hit_b = wb_valid_q & (|wb_mask_q) & (i_rs2_addr == wb_rd_q);

   assign is_alu = (i_opcode <= OP_XOR);
   assign is_ld  = (i_opcode == OP_LD);
   assign is_st  = (i_opcode == OP_ST);

`ifdef SHADER_FWD_EN
   assign instr_ready = ~rst & (state_q == ST_IDLE);
`else
   logic hazard;
   assign hazard      = hit_a | hit_b;
   assign instr_ready = ~rst & (state_q == ST_IDLE) & ~hazard;
`endif

   assign accept        = i_instr_valid & instr_ready;
   assign mem_handshake = (state_q == ST_MEM) & i_mem_ready;

   genvar gi;
   generate
      for (gi = 0; gi < VEC_SIZE; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] a, b, res;
`ifdef SHADER_FWD_EN
         assign a = (hit_a & wb_mask_q[gi]) ? wb_data_q[gi*DATA_WIDTH +: DATA_WIDTH]
                                            : rs1_rf[gi*DATA_WIDTH +: DATA_WIDTH];
         assign b = (hit_b & wb_mask_q[gi]) ? wb_data_q[gi*DATA_WIDTH +: DATA_WIDTH]
                                            : rs2_rf[gi*DATA_WIDTH +: DATA_WIDTH];
`else
         assign a = rs1_rf[gi*DATA_WIDTH +: DATA_WIDTH];
         assign b = rs2_rf[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
         always_comb begin
            res = '0;
            case (i_opcode)
               OP_ADD:  res = a + b;
               OP_SUB:  res = a - b;
               OP_MUL:  res = a * b;
               OP_AND:  res = a & b;
               OP_OR:   res = a | b;
               OP_XOR:  res = a ^ b;
               default: res = '0;
            endcase
         end
         assign op_a[gi*DATA_WIDTH +: DATA_WIDTH]    = a;
         assign op_b[gi*DATA_WIDTH +: DATA_WIDTH]    = b;
         assign alu_res[gi*DATA_WIDTH +: DATA_WIDTH] = res;
         // Unmasked lanes rewrite their current contents.
         assign wb_merge[gi*DATA_WIDTH +: DATA_WIDTH] = wb_mask_q[gi]
            ? wb_data_q[gi*DATA_WIDTH +: DATA_WIDTH]
            : rf_q[wb_rd_q][gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_mask_d  = wb_mask_q;
      wb_data_d  = wb_data_q;
      case (state_q)
         ST_IDLE: if (accept & (is_ld | is_st)) state_d = ST_MEM;
         ST_MEM:  if (i_mem_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (mem_handshake) begin
         wb_valid_d = ~mem_we_q;
         wb_rd_d    = ld_rd_q;
         wb_mask_d  = ld_mask_q;
         wb_data_d  = i_mem_rdata;
      end else if (accept & is_alu) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = i_rd_addr;
         wb_mask_d  = i_lane_mask;
         wb_data_d  = alu_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_mask_q   <= '0;
         wb_data_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ld_rd_q     <= '0;
         ld_mask_q   <= '0;
         for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_mask_q  <= wb_mask_d;
         wb_data_q  <= wb_data_d;
         if (accept & (is_ld | is_st)) begin
            mem_we_q    <= is_st;
            mem_addr_q  <= op_a[DATA_WIDTH-1:0];
            mem_wdata_q <= op_b;
            ld_rd_q     <= i_rd_addr;
            ld_mask_q   <= i_lane_mask;
         end
         if (wb_valid_q) rf_q[wb_rd_q] <= wb_merge;
      end
   end

   assign o_instr_ready = instr_ready;
   assign o_mem_req     = (state_q == ST_MEM);
   assign o_mem_we      = mem_we_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_mem_wdata   = mem_wdata_q;
   assign o_busy        = wb_valid_q | (state_q == ST_MEM);

endmodule

// File: tb/tb_vector_shader_core.sv
// Bench for vector_shader_core: registers are read back through ST requests checked by a scoreboard.
module tb_vector_shader_core;
   localparam int DW = 32;
   localparam int VS = 4;
   localparam int NR = 16;
   localparam int RW = 4;
   localparam int VW = VS * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_instr_valid = 1'b0;
   logic          o_instr_ready;
   logic [4:0]    i_opcode = '0;
   logic [RW-1:0] i_rd_addr = '0, i_rs1_addr = '0, i_rs2_addr = '0;
   logic [VS-1:0] i_lane_mask = '0;
   logic          o_mem_req, o_mem_we;
   logic [DW-1:0] o_mem_addr;
   logic [VW-1:0] o_mem_wdata;
   logic          i_mem_ready = 1'b0;
   logic [VW-1:0] i_mem_rdata = '0;
   logic          o_busy;

   vector_shader_core #(.DATA_WIDTH(DW), .VEC_SIZE(VS), .NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst),
      .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
      .i_opcode(i_opcode), .i_rd_addr(i_rd_addr), .i_rs1_addr(i_rs1_addr),
      .i_rs2_addr(i_rs2_addr), .i_lane_mask(i_lane_mask),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [DW-1:0] addr;
      logic [VW-1:0] wdata;
      logic          chk_wdata;
   } mem_exp_t;

   typedef struct {
      logic [4:0]    op;
      logic [RW-1:0] rd, rs1, rs2;
      logic [VS-1:0] mask;
      logic [VW-1:0] exp;
   } vec_t;

   mem_exp_t      sb[$];
   mem_exp_t      cur;
   int            checks = 0, failures = 0;
   int            mem_delay = 1, req_cnt = 0, last_req_len = 0;
   logic [VW-1:0] mem_rdata = '0;

   function automatic logic [VW-1:0] v4(input logic [DW-1:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else
         $display("ok   %s value=%h", name, act);
   endtask

   // Memory model: answers after mem_delay request cycles, checks each new request against the scoreboard.
   always @(negedge clk) begin
      if (o_mem_req) begin
         checks++;
         if (o_instr_ready) begin
            failures++;
            $display("FAIL ready_during_req actual=1 required=0");
         end
         if (req_cnt == 0) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_req actual=we%0d addr=%h required=no request", o_mem_we, o_mem_addr);
            end else begin
               cur = sb.pop_front();
               if (o_mem_we !== cur.we || o_mem_addr !== cur.addr ||
                   (cur.chk_wdata && o_mem_wdata !== cur.wdata)) begin
                  failures++;
                  $display("FAIL mem_req actual=we%0d addr=%h wdata=%h required=we%0d addr=%h wdata=%h",
                           o_mem_we, o_mem_addr, o_mem_wdata, cur.we, cur.addr, cur.wdata);
               end else
                  $display("ok   mem_req we=%0d addr=%h wdata=%h", o_mem_we, o_mem_addr, o_mem_wdata);
            end
         end
         req_cnt++;
         if (req_cnt >= mem_delay) begin
            i_mem_ready  = 1'b1;
            i_mem_rdata  = mem_rdata;
            last_req_len = req_cnt;
         end else
            i_mem_ready = 1'b0;
      end else begin
         req_cnt     = 0;
         i_mem_ready = 1'b0;
      end
   end

   task automatic push_exp(input logic we, input logic [DW-1:0] addr, input logic [VW-1:0] wdata,
                           input logic chk);
      mem_exp_t x;
      x.we = we; x.addr = addr; x.wdata = wdata; x.chk_wdata = chk;
      sb.push_back(x);
   endtask

   task automatic issue(input logic [4:0] op, input logic [RW-1:0] rd, rs1, rs2,
                        input logic [VS-1:0] mask, output int stalls);
      @(negedge clk);
      i_opcode = op; i_rd_addr = rd; i_rs1_addr = rs1; i_rs2_addr = rs2; i_lane_mask = mask;
      i_instr_valid = 1'b1;
      stalls = 0;
      #1;
      while (!o_instr_ready && stalls < 50) begin
         @(negedge clk); #1;
         stalls++;
      end
      if (!o_instr_ready) begin
         checks++; failures++;
         $display("FAIL issue_timeout actual=ready 0 for %0d cycles required=accept", stalls);
      end
      @(posedge clk); #1;
      i_instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((o_busy || o_mem_req) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (o_busy || o_mem_req) begin
         checks++; failures++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   // Stores Rr with address taken from R0 (never written), so the store data exposes Rr.
   task automatic read_reg(input logic [RW-1:0] r, input logic [VW-1:0] exp);
      int s;
      push_exp(1'b1, 32'h0, exp, 1'b1);
      issue(5'd7, 4'd0, 4'd0, r, 4'h0, s);
      wait_idle();
   endtask

   task automatic load(input logic [RW-1:0] rd, input logic [VW-1:0] data, input logic [VS-1:0] mask);
      int s;
      mem_rdata = data;
      push_exp(1'b0, 32'h0, '0, 1'b0);
      issue(5'd6, rd, 4'd0, 4'd0, mask, s);
      wait_idle();
   endtask

   vec_t tbl[9];
   int   s1, s2, exp_stall;

   initial begin
      tbl[0] = '{5'd0,  4'd4,  4'd1, 4'd2, 4'b0101, v4(32'd2, 32'd0, 32'd4, 32'd0)};
      tbl[1] = '{5'd1,  4'd5,  4'd1, 4'd2, 4'hF, v4(32'd0, 32'd1, 32'd2, 32'hFFFFFFFE)};
      tbl[2] = '{5'd2,  4'd10, 4'd1, 4'd1, 4'hF, v4(32'd1, 32'd4, 32'd9, 32'd1)};
      tbl[3] = '{5'd3,  4'd11, 4'd1, 4'd2, 4'hF, v4(32'd1, 32'd0, 32'd1, 32'd1)};
      tbl[4] = '{5'd4,  4'd12, 4'd1, 4'd2, 4'hF, v4(32'd1, 32'd3, 32'd3, 32'hFFFFFFFF)};
      tbl[5] = '{5'd5,  4'd13, 4'd1, 4'd2, 4'hF, v4(32'd0, 32'd3, 32'd2, 32'hFFFFFFFE)};
      tbl[6] = '{5'd5,  4'd13, 4'd1, 4'd1, 4'h0, v4(32'd0, 32'd3, 32'd2, 32'hFFFFFFFE)};
      tbl[7] = '{5'd0,  4'd4,  4'd1, 4'd1, 4'b1010, v4(32'd2, 32'd4, 32'd4, 32'hFFFFFFFE)};
      tbl[8] = '{5'd31, 4'd5,  4'd1, 4'd2, 4'hF, v4(32'd0, 32'd1, 32'd2, 32'hFFFFFFFE)};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {127'd0, o_instr_ready}, '0);
      check("rst_req",   {127'd0, o_mem_req}, '0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", {127'd0, o_instr_ready}, 128'd1);
      check("post_rst_we",    {127'd0, o_mem_we}, '0);
      check("post_rst_addr",  {96'd0, o_mem_addr}, '0);
      check("post_rst_wdata", o_mem_wdata, '0);
      check("post_rst_busy",  {127'd0, o_busy}, '0);

      issue(5'd0, 4'd3, 4'd1, 4'd2, 4'hF, s1);
      check("busy_after_add", {127'd0, o_busy}, 128'd1);
      @(posedge clk); #1;
      check("busy_cleared", {127'd0, o_busy}, '0);
      read_reg(4'd3, '0);

      load(4'd1, v4(32'd1, 32'd2, 32'd3, 32'hFFFFFFFF), 4'hF);
      load(4'd2, v4(32'd1, 32'd1, 32'd1, 32'd1), 4'hF);
      read_reg(4'd1, v4(32'd1, 32'd2, 32'd3, 32'hFFFFFFFF));

      for (int i = 0; i < 9; i++) begin
         issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].mask, s1);
         if (tbl[i].op == 5'd31) begin
            @(posedge clk); #1;
            check("nop_no_req", {127'd0, o_mem_req}, '0);
         end
         wait_idle();
         read_reg(tbl[i].rd, tbl[i].exp);
      end

`ifdef SHADER_FWD_EN
      exp_stall = 0;
`else
      exp_stall = 1;
`endif
      issue(5'd0, 4'd6, 4'd1, 4'd2, 4'hF, s1);
      issue(5'd2, 4'd7, 4'd6, 4'd6, 4'hF, s2);
      check("raw_first_stall", 128'(s1), '0);
      check("raw_second_stall", 128'(s2), 128'(exp_stall));
      wait_idle();
      read_reg(4'd7, v4(32'd4, 32'd9, 32'd16, 32'd0));

      load(4'd15, v4(32'h100, 32'd5, 32'd6, 32'd7), 4'hF);
      mem_delay = 3;
      push_exp(1'b1, 32'h100, v4(32'd1, 32'd1, 32'd1, 32'd1), 1'b1);
      issue(5'd7, 4'd0, 4'd15, 4'd2, 4'hF, s1);
      wait_idle();
      check("st_req_len", 128'(last_req_len), 128'd3);
      mem_delay = 2;
      load(4'd8, v4(32'hA, 32'hB, 32'hC, 32'hD), 4'hF);
      mem_delay = 1;
      read_reg(4'd8, v4(32'hA, 32'hB, 32'hC, 32'hD));

      mem_delay = 100;
      mem_rdata = v4(32'h11, 32'h22, 32'h33, 32'h44);
      push_exp(1'b0, 32'h0, '0, 1'b0);
      issue(5'd6, 4'd9, 4'd0, 4'd0, 4'hF, s1);
      check("ld_req_pending", {127'd0, o_mem_req}, 128'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_req_low", {127'd0, o_mem_req}, '0);
      check("abort_ready_low", {127'd0, o_instr_ready}, '0);
      @(negedge clk);
      rst = 1'b0;
      mem_delay = 1;
      #1;
      check("abort_ready_high", {127'd0, o_instr_ready}, 128'd1);
      read_reg(4'd9, '0);

      check("sb_empty", 128'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
